// File: rtl/sirv_queue_wm.sv
// rtl/sirv_queue_wm.sv - parametrised ready/valid FIFO with count, watermarks, flush and overflow flag
//
// Purpose:
//   Synchronous FIFO for peripheral TX/RX buffering. It provides a registered
//   occupancy count, high/low watermark flags that are aligned with the count,
//   a synchronous flush, and a sticky overflow flag.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous active-low reset (0 = reset)
//   io_enq_*      enqueue side: ready out, valid/bits in
//   io_deq_*      dequeue side: ready in, valid/bits out
//   io_count      registered occupancy, 0..DEPTH
//   io_flush      discard all entries at the next edge
//   io_hiwm_lvl   high watermark threshold; io_hiwm = count > lvl
//   io_lowm_lvl   low watermark threshold;  io_lowm = count < lvl
//   io_ovf        sticky flag: enqueue attempted while full
//   io_ovf_clr    clears io_ovf (a simultaneous set wins)

module sirv_queue_wm #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       io_enq_ready,
  input  logic                       io_enq_valid,
  input  logic [WIDTH-1:0]           io_enq_bits,
  input  logic                       io_deq_ready,
  output logic                       io_deq_valid,
  output logic [WIDTH-1:0]           io_deq_bits,
  output logic [$clog2(DEPTH):0]     io_count,
  input  logic                       io_flush,
  input  logic [$clog2(DEPTH):0]     io_hiwm_lvl,
  input  logic [$clog2(DEPTH):0]     io_lowm_lvl,
  output logic                       io_hiwm,
  output logic                       io_lowm,
  output logic                       io_ovf,
  input  logic                       io_ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Storage holds no reset: occupancy is tracked by cnt, so stale entries
  // are never observable.
  logic [WIDTH-1:0] ram_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          hiwm_q, hiwm_d;
  logic          lowm_q, lowm_d;
  logic          ovf_q, ovf_d;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  logic ovf_set;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // Handshake outputs depend only on state and flush, never on the opposite
  // side's valid/ready, so there is no enq-to-deq combinational path.
  assign io_enq_ready = ~full & ~io_flush;
  assign io_deq_valid = ~empty & ~io_flush;

  assign enq = io_enq_valid & io_enq_ready;
  assign deq = io_deq_ready & io_deq_valid;

  assign ovf_set = io_enq_valid & full & ~io_flush;

  assign io_deq_bits = ram_q[rptr_q];
  assign io_count    = cnt_q;
  assign io_hiwm     = hiwm_q;
  assign io_lowm     = lowm_q;
  assign io_ovf      = ovf_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    if (io_flush) begin
      // enq/deq are already masked off by the handshake decode.
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq) wptr_d = wptr_q + AW'(1);
      if (deq) rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
    end

    // Flags are computed from the next count so they stay aligned with io_count.
    hiwm_d = (cnt_d > io_hiwm_lvl);
    lowm_d = (cnt_d < io_lowm_lvl);

    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (io_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      hiwm_q <= 1'b0;
      lowm_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      hiwm_q <= hiwm_d;
      lowm_q <= lowm_d;
      ovf_q  <= ovf_d;
    end
  end

  // The write is gated by reset so that a reset cycle cannot leave a write behind.
  always_ff @(posedge clock) begin
    if (reset && enq) begin
      ram_q[wptr_q] <= io_enq_bits;
    end
  end

endmodule

// File: tb/tb_sirv_queue_wm.sv
// tb/tb_sirv_queue_wm.sv - directed self-checking bench for sirv_queue_wm

module tb_sirv_queue_wm;

  logic       clock;
  logic       reset;
  logic       io_enq_ready;
  logic       io_enq_valid;
  logic [7:0] io_enq_bits;
  logic       io_deq_ready;
  logic       io_deq_valid;
  logic [7:0] io_deq_bits;
  logic [3:0] io_count;
  logic       io_flush;
  logic [3:0] io_hiwm_lvl;
  logic [3:0] io_lowm_lvl;
  logic       io_hiwm;
  logic       io_lowm;
  logic       io_ovf;
  logic       io_ovf_clr;

  int n_cmp;
  int n_bad;

  sirv_queue_wm #(.WIDTH(8), .DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_enq_ready (io_enq_ready),
    .io_enq_valid (io_enq_valid),
    .io_enq_bits  (io_enq_bits),
    .io_deq_ready (io_deq_ready),
    .io_deq_valid (io_deq_valid),
    .io_deq_bits  (io_deq_bits),
    .io_count     (io_count),
    .io_flush     (io_flush),
    .io_hiwm_lvl  (io_hiwm_lvl),
    .io_lowm_lvl  (io_lowm_lvl),
    .io_hiwm      (io_hiwm),
    .io_lowm      (io_lowm),
    .io_ovf       (io_ovf),
    .io_ovf_clr   (io_ovf_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io_enq_valid = 1'b0;
    io_enq_bits  = 8'h00;
    io_deq_ready = 1'b0;
    io_flush     = 1'b0;
    io_ovf_clr   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    io_hiwm_lvl = 4'd8;
    io_lowm_lvl = 4'd0;
    reset = 1'b0;
    tick();
    n_cmp++;
    if (io_enq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_enq_ready got %0b want 1", io_enq_ready); end
    n_cmp++;
    if (io_deq_valid !== 1'b0) begin n_bad++; $display("FAIL reset_deq_valid got %0b want 0", io_deq_valid); end
    n_cmp++;
    if (io_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", io_count); end
    n_cmp++;
    if (io_hiwm !== 1'b0) begin n_bad++; $display("FAIL reset_hiwm got %0b want 0", io_hiwm); end
    n_cmp++;
    if (io_lowm !== 1'b1) begin n_bad++; $display("FAIL reset_lowm got %0b want 1", io_lowm); end
    n_cmp++;
    if (io_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0b want 0", io_ovf); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      io_enq_valid = 1'b1;
      io_enq_bits  = 8'(i);
      tick();
      n_cmp++;
      if (io_count !== 4'(i)) begin n_bad++; $display("FAIL fill_count got %0d want %0d", io_count, i); end
    end
    io_enq_valid = 1'b0;
    n_cmp++;
    if (io_enq_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready got %0b want 0", io_enq_ready); end
    io_deq_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (io_deq_valid !== 1'b1 || io_deq_bits !== 8'(i)) begin
        n_bad++; $display("FAIL drain_data got v=%0b %02h want v=1 %02h", io_deq_valid, io_deq_bits, i);
      end
      tick();
      n_cmp++;
      if (io_count !== 4'(8 - i)) begin n_bad++; $display("FAIL drain_count got %0d want %0d", io_count, 8 - i); end
    end
    io_deq_ready = 1'b0;
    n_cmp++;
    if (io_deq_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty_valid got %0b want 0", io_deq_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      io_enq_valid = 1'b1;
      io_enq_bits  = 8'(8'h10 + i);
      tick();
    end
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (io_deq_bits !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL wrap_pre_data got %02h want %02h", io_deq_bits, 8'h10 + i); end
      tick();
    end
    io_enq_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      io_enq_bits = 8'(8'h20 + i);
      if (i > 0) begin
        n_cmp++;
        if (io_deq_valid !== 1'b1 || io_deq_bits !== 8'(8'h20 + i - 1)) begin
          n_bad++; $display("FAIL stream_data got v=%0b %02h want v=1 %02h", io_deq_valid, io_deq_bits, 8'h20 + i - 1);
        end
      end
      tick();
      n_cmp++;
      if (io_count !== 4'd1) begin n_bad++; $display("FAIL stream_count got %0d want 1", io_count); end
    end
    io_enq_valid = 1'b0;
    n_cmp++;
    if (io_deq_bits !== 8'h33) begin n_bad++; $display("FAIL stream_last got %02h want 33", io_deq_bits); end
    tick();
    io_deq_ready = 1'b0;
    n_cmp++;
    if (io_count !== 4'd0) begin n_bad++; $display("FAIL stream_end_count got %0d want 0", io_count); end
  endtask

  task automatic test_watermarks();
    logic exp_hi;
    logic exp_lo;
    io_hiwm_lvl = 4'd5;
    io_lowm_lvl = 4'd2;
    tick();
    n_cmp++;
    if (io_hiwm !== 1'b0 || io_lowm !== 1'b1) begin
      n_bad++; $display("FAIL wm_idle got hi=%0b lo=%0b want hi=0 lo=1", io_hiwm, io_lowm);
    end
    io_enq_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      io_enq_bits = 8'(8'h40 + k);
      tick();
      exp_hi = (k == 6);
      exp_lo = (k == 1);
      n_cmp++;
      if (io_count !== 4'(k) || io_hiwm !== exp_hi || io_lowm !== exp_lo) begin
        n_bad++; $display("FAIL wm_fill got cnt=%0d hi=%0b lo=%0b want cnt=%0d hi=%0b lo=%0b",
                          io_count, io_hiwm, io_lowm, k, exp_hi, exp_lo);
      end
    end
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b1;
    for (int k = 5; k >= 0; k--) begin
      tick();
      exp_hi = 1'b0;
      exp_lo = (k <= 1);
      n_cmp++;
      if (io_count !== 4'(k) || io_hiwm !== exp_hi || io_lowm !== exp_lo) begin
        n_bad++; $display("FAIL wm_drain got cnt=%0d hi=%0b lo=%0b want cnt=%0d hi=%0b lo=%0b",
                          io_count, io_hiwm, io_lowm, k, exp_hi, exp_lo);
      end
    end
    io_deq_ready = 1'b0;
    io_hiwm_lvl = 4'd8;
    io_lowm_lvl = 4'd0;
    tick();
  endtask

  task automatic test_overflow();
    io_enq_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io_enq_bits = 8'(8'h30 + i);
      tick();
    end
    io_enq_bits = 8'hAA;
    tick();
    n_cmp++;
    if (io_ovf !== 1'b1 || io_count !== 4'd8) begin
      n_bad++; $display("FAIL ovf_set got ovf=%0b cnt=%0d want ovf=1 cnt=8", io_ovf, io_count);
    end
    io_ovf_clr = 1'b1;
    tick();
    n_cmp++;
    if (io_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %0b want 1", io_ovf); end
    io_enq_valid = 1'b0;
    tick();
    n_cmp++;
    if (io_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %0b want 0", io_ovf); end
    io_ovf_clr = 1'b0;
    io_deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (io_deq_bits !== 8'(8'h30 + i)) begin n_bad++; $display("FAIL ovf_data got %02h want %02h", io_deq_bits, 8'h30 + i); end
      tick();
    end
    io_deq_ready = 1'b0;
    n_cmp++;
    if (io_count !== 4'd0 || io_deq_valid !== 1'b0) begin
      n_bad++; $display("FAIL ovf_drained got cnt=%0d v=%0b want cnt=0 v=0", io_count, io_deq_valid);
    end
  endtask

  task automatic test_flush();
    io_enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_enq_bits = 8'(8'h40 + i);
      tick();
    end
    io_lowm_lvl  = 4'd3;
    io_enq_bits  = 8'h99;
    io_deq_ready = 1'b1;
    io_flush     = 1'b1;
    #1;
    n_cmp++;
    if (io_enq_ready !== 1'b0 || io_deq_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_mask got rdy=%0b v=%0b want rdy=0 v=0", io_enq_ready, io_deq_valid);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (io_count !== 4'd0 || io_deq_valid !== 1'b0 || io_lowm !== 1'b1 || io_hiwm !== 1'b0) begin
      n_bad++; $display("FAIL flush_state got cnt=%0d v=%0b lo=%0b hi=%0b want cnt=0 v=0 lo=1 hi=0",
                        io_count, io_deq_valid, io_lowm, io_hiwm);
    end
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'h55;
    tick();
    io_enq_valid = 1'b0;
    n_cmp++;
    if (io_deq_valid !== 1'b1 || io_deq_bits !== 8'h55) begin
      n_bad++; $display("FAIL flush_first got v=%0b %02h want v=1 55", io_deq_valid, io_deq_bits);
    end
    io_deq_ready = 1'b1;
    tick();
    io_deq_ready = 1'b0;
    io_lowm_lvl  = 4'd0;
    tick();
  endtask

  task automatic test_reset_mid();
    io_hiwm_lvl  = 4'd3;
    io_enq_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io_enq_bits = 8'(8'h60 + i);
      tick();
    end
    tick();
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (io_count !== 4'd6 || io_ovf !== 1'b1 || io_hiwm !== 1'b1 || io_lowm !== 1'b0) begin
      n_bad++; $display("FAIL mid_pre got cnt=%0d ovf=%0b hi=%0b lo=%0b want cnt=6 ovf=1 hi=1 lo=0",
                        io_count, io_ovf, io_hiwm, io_lowm);
    end
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'hEE;
    reset = 1'b0;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (io_count !== 4'd0 || io_enq_ready !== 1'b1 || io_deq_valid !== 1'b0 ||
        io_hiwm !== 1'b0 || io_lowm !== 1'b1 || io_ovf !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset got cnt=%0d rdy=%0b v=%0b hi=%0b lo=%0b ovf=%0b want 0 1 0 0 1 0",
                        io_count, io_enq_ready, io_deq_valid, io_hiwm, io_lowm, io_ovf);
    end
    reset = 1'b1;
    io_enq_valid = 1'b1;
    io_enq_bits  = 8'h77;
    tick();
    io_enq_valid = 1'b0;
    n_cmp++;
    if (io_count !== 4'd1 || io_deq_bits !== 8'h77) begin
      n_bad++; $display("FAIL mid_after got cnt=%0d %02h want cnt=1 77", io_count, io_deq_bits);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    io_hiwm_lvl = 4'd8;
    io_lowm_lvl = 4'd0;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_watermarks();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
